// File: rtl/mem_copy_engine_if.sv
// rtl/mem_copy_engine_if.sv - request/status and memory-port bundle for mem_copy_engine
interface mem_copy_engine_if;
    logic        start;
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_out;

    // master: requester plus attached memory; slave: the copy engine
    modport master (
        output start, src, dst, len, mem_out,
        input  busy, done, err, mem_addr, mem_din, mem_we, mem_re
    );

    modport slave (
        input  start, src, dst, len, mem_out,
        output busy, done, err, mem_addr, mem_din, mem_we, mem_re
    );
endinterface

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - word-by-word forward memory copy with range check
module mem_copy_engine #(
    parameter int unsigned SIZE = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_copy_engine_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CHECK, READ, WRITE, FIN} state_t;

    localparam logic [32:0] LIMIT = 33'(SIZE);

    state_t      state;
    logic [31:0] src_q;
    logic [31:0] dst_q;
    logic [31:0] len_q;
    logic [31:0] idx;
    logic [31:0] data_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic        we_q;
    logic        re_q;
    logic [31:0] addr_q;

    logic [32:0] src_end;
    logic [32:0] dst_end;
    logic        range_bad;
    logic [31:0] idx_next;

    // The range verdict is evaluated from the request as it is captured so
    // that err can be a registered pulse that lines up with the CHECK cycle.
    assign src_end   = {1'b0, bus.src} + {1'b0, bus.len};
    assign dst_end   = {1'b0, bus.dst} + {1'b0, bus.len};
    assign range_bad = (src_end > LIMIT) || (dst_end > LIMIT);
    assign idx_next  = idx + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            idx    <= '0;
            data_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            we_q   <= 1'b0;
            re_q   <= 1'b0;
            addr_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            we_q   <= 1'b0;
            re_q   <= 1'b0;
            addr_q <= '0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        src_q  <= bus.src;
                        dst_q  <= bus.dst;
                        len_q  <= bus.len;
                        idx    <= '0;
                        err_q  <= range_bad;
                        busy_q <= 1'b1;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (err_q) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (len_q == '0) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= FIN;
                    end else begin
                        re_q   <= 1'b1;
                        addr_q <= src_q;
                        state  <= READ;
                    end
                end
                READ: begin
                    data_q <= bus.mem_out;
                    we_q   <= 1'b1;
                    addr_q <= dst_q + idx;
                    state  <= WRITE;
                end
                WRITE: begin
                    idx <= idx_next;
                    if (idx_next == len_q) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= FIN;
                    end else begin
                        re_q   <= 1'b1;
                        addr_q <= src_q + idx_next;
                        state  <= READ;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.mem_we   = we_q;
    assign bus.mem_re   = re_q;
    assign bus.mem_addr = addr_q;
    // write data is only presented while the write enable is up
    assign bus.mem_din  = we_q ? data_q : '0;
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - directed vector bench for mem_copy_engine
module tb_mem_copy_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_copy_engine_if bus ();

    mem_copy_engine #(.SIZE(256)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem     [0:255];
    logic [31:0] exp_mem [0:255];
    logic        init_go = 1'b0;
    logic        poke_en = 1'b0;
    logic [7:0]  poke_a  = 8'd0;
    logic [31:0] poke_v  = 32'd0;

    always @(posedge clk) begin
        if (init_go) begin
            for (int k = 0; k < 256; k++) mem[k] <= 32'(k + 1);
            if (poke_en) mem[poke_a] <= poke_v;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[7:0]] <= bus.mem_din;
        end
    end

    assign bus.mem_out = bus.mem_re ? mem[bus.mem_addr[7:0]] : 32'h0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    endtask

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
        int          exp_cyc;
        bit          exp_err;
        bit          poke;
        logic [31:0] poke_v;
    } vec_t;

    vec_t vecs [10];

    int done_cyc, err_cyc, done_cnt, err_cnt, busy_cnt, re_cnt, we_cnt, both_cnt, idle_bad;

    task automatic clear_stats();
        done_cyc = -1; err_cyc = -1; done_cnt = 0; err_cnt = 0; busy_cnt = 0;
        re_cnt = 0; we_cnt = 0; both_cnt = 0; idle_bad = 0;
    endtask

    task automatic sample(input int c);
        if (bus.done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
        if (bus.err)  begin err_cnt++;  if (err_cyc < 0)  err_cyc = c; end
        if (bus.busy)   busy_cnt++;
        if (bus.mem_re) re_cnt++;
        if (bus.mem_we) we_cnt++;
        if (bus.mem_re && bus.mem_we) both_cnt++;
        if (!bus.mem_re && !bus.mem_we && (bus.mem_addr != 0 || bus.mem_din != 0)) idle_bad++;
    endtask

    task automatic init_mem(input bit pe, input logic [7:0] pa, input logic [31:0] pv);
        @(negedge clk);
        init_go = 1'b1; poke_en = pe; poke_a = pa; poke_v = pv;
        @(posedge clk);
        #1 init_go = 1'b0; poke_en = 1'b0;
        for (int k = 0; k < 256; k++) exp_mem[k] = 32'(k + 1);
        if (pe) exp_mem[pa] = pv;
    endtask

    task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
        for (int k = 0; k < int'(n); k++) exp_mem[8'(d + 32'(k))] = exp_mem[8'(s + 32'(k))];
    endtask

    function automatic int mem_mismatches();
        int m = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== exp_mem[k]) m++;
        return m;
    endfunction

    function automatic logic [99:0] outs();
        return {bus.busy, bus.done, bus.err, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_din};
    endfunction

    initial begin
        bus.start = 1'b0; bus.src = '0; bus.dst = '0; bus.len = '0;

        vecs[0] = '{3,   10,  1, 4,  1'b0, 1'b1, 17};
        vecs[1] = '{0,   100, 4, 10, 1'b0, 1'b0, 0};
        vecs[2] = '{250, 0,   7, 1,  1'b1, 1'b0, 0};
        vecs[3] = '{0,   0,   0, 2,  1'b0, 1'b0, 0};
        vecs[4] = '{249, 0,   7, 16, 1'b0, 1'b0, 0};
        vecs[5] = '{0,   249, 8, 1,  1'b1, 1'b0, 0};
        vecs[6] = '{10,  12,  5, 12, 1'b0, 1'b0, 0};
        vecs[7] = '{20,  15,  4, 10, 1'b0, 1'b0, 0};
        vecs[8] = '{32'hFFFF_FFFF, 0, 2, 1, 1'b1, 1'b0, 0};
        vecs[9] = '{256, 0,   0, 2,  1'b0, 1'b0, 0};

        #1 check("reset_outputs", 64'(outs() != 0), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 10; v++) begin
            init_mem(vecs[v].poke, vecs[v].src[7:0], vecs[v].poke_v);
            if (!vecs[v].exp_err) model_copy(vecs[v].src, vecs[v].dst, vecs[v].len);
            @(negedge clk);
            bus.src = vecs[v].src; bus.dst = vecs[v].dst; bus.len = vecs[v].len; bus.start = 1'b1;
            @(posedge clk);
            #1 bus.start = 1'b0;
            clear_stats();
            for (int c = 1; c <= 40; c++) begin
                @(negedge clk);
                sample(c);
            end
            check($sformatf("v%0d_event_cycle", v), vecs[v].exp_err ? err_cyc : done_cyc, vecs[v].exp_cyc);
            check($sformatf("v%0d_done_cnt", v), done_cnt, vecs[v].exp_err ? 0 : 1);
            check($sformatf("v%0d_err_cnt", v), err_cnt, vecs[v].exp_err ? 1 : 0);
            check($sformatf("v%0d_re_cnt", v), re_cnt, vecs[v].exp_err ? 0 : vecs[v].len);
            check($sformatf("v%0d_we_cnt", v), we_cnt, vecs[v].exp_err ? 0 : vecs[v].len);
            check($sformatf("v%0d_busy_cycles", v), busy_cnt, vecs[v].exp_err ? 1 : 2 * vecs[v].len + 1);
            check($sformatf("v%0d_we_re_overlap", v), both_cnt, 0);
            check($sformatf("v%0d_idle_bus_nonzero", v), idle_bad, 0);
            check($sformatf("v%0d_mem_mismatch", v), mem_mismatches(), 0);
        end

        // abort by reset during the third write of an 8-word copy
        init_mem(1'b0, 8'd0, 32'd0);
        model_copy(0, 50, 2);
        @(negedge clk);
        bus.src = 0; bus.dst = 50; bus.len = 8; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        clear_stats();
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            sample(c);
        end
        check("abort_third_write_we", bus.mem_we, 1);
        check("abort_third_write_addr", bus.mem_addr, 52);
        rst_n = 1'b0;
        #1 check("abort_outputs_async", 64'(outs() != 0), 0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            sample(c);
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_mem_mismatch", mem_mismatches(), 0);

        // first posedge after reset release accepts a start
        bus.src = 0; bus.dst = 0; bus.len = 0; bus.start = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        check("post_reset_busy_c1", bus.busy, 1);
        @(negedge clk);
        check("post_reset_done_c2", bus.done, 1);
        repeat (3) @(negedge clk);

        // start held high: one copy, re-accepted only at the first IDLE edge after done
        init_mem(1'b0, 8'd0, 32'd0);
        model_copy(0, 60, 2);
        @(negedge clk);
        bus.src = 0; bus.dst = 60; bus.len = 2; bus.start = 1'b1;
        @(posedge clk);
        clear_stats();
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            sample(c);
        end
        check("hold_first_done_cycle", done_cyc, 6);
        check("hold_done_cnt_first", done_cnt, 1);
        check("hold_idle_busy_c7", bus.busy, 0);
        @(negedge clk);
        sample(8);
        check("hold_reaccept_busy_c8", bus.busy, 1);
        bus.start = 1'b0;
        for (int c = 9; c <= 20; c++) begin
            @(negedge clk);
            sample(c);
        end
        check("hold_done_cnt_total", done_cnt, 2);
        check("hold_busy_cycles", busy_cnt, 10);
        check("hold_mem_mismatch", mem_mismatches(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
